// File: rtl/uart_tx.sv
// UART serial transmitter: start, LSB-first data, optional parity, stop.
// One bit per baud clock; back-to-back frames accepted during STOP.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_q, par_d;
    logic                  par_en_q, par_en_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  tx_d, busy_d;
    logic                  accept;

    assign accept = Data_Valid && (state_q == IDLE || state_q == STOP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            cnt_q    <= '0;
            TX_OUT   <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            cnt_q    <= cnt_d;
            TX_OUT   <= tx_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        cnt_d    = cnt_q;
        tx_d     = 1'b1;
        busy_d   = 1'b0;

        unique case (state_q)
            IDLE, STOP: begin
                if (accept) begin
                    state_d  = START;
                    data_d   = P_DATA;
                    par_en_d = PAR_EN;
                    par_d    = (^P_DATA) ^ PAR_TYP;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: state_d = STOP;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave a register.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[cnt_d];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: hand-computed bit sequences per frame.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       busy;

    int total = 0;
    int bad = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .P_DATA(P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .TX_OUT(TX_OUT),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Caller has set inputs with Data_Valid=1; s lists TX_OUT per cycle.
    // poke>=0 pulses Data_Valid with P_DATA=55 and flips PAR_TYP there.
    task automatic run_frame(input string name, input string s,
                             input bit keep_dv, input int poke);
        for (int i = 0; i < s.len(); i++) begin
            tick();
            if (i == 0 && !keep_dv) Data_Valid = 1'b0;
            if (poke >= 0 && i == poke + 1) Data_Valid = 1'b0;
            chk($sformatf("%s tx[%0d]", name, i), TX_OUT, s[i] == "1");
            chk($sformatf("%s busy[%0d]", name, i), busy, 1'b1);
            if (i == poke) begin
                Data_Valid = 1'b1;
                P_DATA = 8'h55;
                PAR_TYP = ~PAR_TYP;
            end
        end
        Data_Valid = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        tick();
        chk({name, " idle tx"}, TX_OUT, 1'b1);
        chk({name, " idle busy"}, busy, 1'b0);
    endtask

    task automatic start(input logic [7:0] d, input logic pe, input logic pt);
        P_DATA = d;
        PAR_EN = pe;
        PAR_TYP = pt;
        Data_Valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        P_DATA = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        tick();
        tick();
        chk("reset tx", TX_OUT, 1'b1);
        chk("reset busy", busy, 1'b0);
        reset = 1'b0;
        chk_idle("post_reset");

        start(8'b10111010, 1'b0, 1'b0);
        run_frame("nopar", "0010111011", 1'b0, -1);
        chk_idle("nopar");

        start(8'b11100100, 1'b1, 1'b0);
        run_frame("even", "00010011101", 1'b0, -1);
        chk_idle("even");

        start(8'b10111010, 1'b1, 1'b1);
        run_frame("odd_ba", "00101110101", 1'b0, -1);
        chk_idle("odd_ba");

        start(8'hFF, 1'b1, 1'b1);
        run_frame("odd_ff", "01111111111", 1'b0, -1);
        chk_idle("odd_ff");

        // Second request lands in the STOP cycle of the first frame
        start(8'hA5, 1'b0, 1'b0);
        run_frame("b2b_1", "0101001011", 1'b0, -1);
        start(8'h3C, 1'b0, 1'b0);
        run_frame("b2b_2", "0001111001", 1'b0, -1);
        chk_idle("b2b");

        // Even parity of 0F is 0; a flipped PAR_TYP would make it 1
        start(8'h0F, 1'b1, 1'b0);
        run_frame("ignore", "01111000001", 1'b0, 3);
        chk_idle("ignore1");
        chk_idle("ignore2");

        start(8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) Data_Valid = 1'b0;
        end
        chk("pre_rst tx bit4", TX_OUT, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst tx", TX_OUT, 1'b1);
        chk("midrst busy", busy, 1'b0);
        tick();
        reset = 1'b0;
        chk_idle("after_rst");

        start(8'h3C, 1'b0, 1'b0);
        run_frame("rec", "0001111001", 1'b0, -1);
        chk_idle("rec");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that produces the UART frame consumed by the receive path: 1 start bit (0), DATA_WIDTH data bits LSB-first, an optional parity bit, and 1 stop bit (1).
- Runs on the baud-rate clock, one bit per clock cycle. The companion receiver runs at prescaler × this rate.
- Accepts parallel words from the upstream register/FIFO interface with a valid/busy handshake. Back-to-back frames are supported with no idle gap.

Parameters:
- DATA_WIDTH, 8, width of the parallel data word and number of data bits per frame.

Ports:
- clk  input  1  baud-rate clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel word to transmit; sampled only on the acceptance edge.
- Data_Valid  input  1  request to transmit P_DATA; single-cycle pulse or held level.
- PAR_EN  input  1  1 = parity bit inserted; sampled on the acceptance edge.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on the acceptance edge.
- TX_OUT  output  1  serial line; idles at 1.
- busy  output  1  high while a frame is being shifted (START through STOP).

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - state = IDLE, TX_OUT = 1, busy = 0.
  - Shift register, bit counter and latched configuration cleared to 0.
  - A partial frame is abandoned. The line returns to 1 at once.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered, so there are no combinational paths from inputs to TX_OUT or busy.
- Acceptance condition: Data_Valid = 1 on a rising edge while state is IDLE or STOP. On that edge:
  - P_DATA, PAR_EN and PAR_TYP are latched.
  - The parity bit is computed as XOR of P_DATA, inverted when PAR_TYP = 1.
  - Next state = START.
- Data_Valid asserted in START, DATA or PARITY is ignored and not queued. The upstream block must hold or re-issue it.
- Changes to P_DATA, PAR_EN or PAR_TYP after acceptance do not affect the frame in flight.
- Latency: TX_OUT = 0 (start bit) and busy = 1 in the cycle immediately after the acceptance edge.
- START: one cycle, TX_OUT = 0. Next state = DATA, bit counter = 0.
- DATA:
  - TX_OUT = latched bit[bit counter]; LSB is sent first.
  - The counter is 3 bits wide for DATA_WIDTH = 8 (generally clog2(DATA_WIDTH)) and increments each cycle.
  - After bit DATA_WIDTH-1, next state = PARITY if the latched PAR_EN = 1, otherwise STOP. There is no counter wrap-around into a 9th bit.
- PARITY: one cycle, TX_OUT = latched parity bit. Next state = STOP.
- STOP: one cycle, TX_OUT = 1, busy = 1.
  - If the acceptance condition holds: next state = START (back-to-back frame, no idle bit).
  - Otherwise: next state = IDLE.
- IDLE: TX_OUT = 1, busy = 0.
- Frame length: 10 cycles with PAR_EN = 0, 11 cycles with PAR_EN = 1. busy is high for exactly that many cycles per frame, and stays continuously high across back-to-back frames.
- Parity rule: even parity makes the total number of 1s (data + parity) even. Odd parity makes it odd.

Test Plan:
- No parity: reset, PAR_EN = 0, P_DATA = 8'b10111010, one-cycle Data_Valid.
  - Required: TX_OUT = 0,0,1,0,1,1,1,0,1,1 on the next 10 cycles.
  - busy high for those 10 cycles, then TX_OUT = 1 and busy = 0.
- Even parity: PAR_EN = 1, PAR_TYP = 0, P_DATA = 8'b11100100.
  - Required: start 0, data 0,0,1,0,0,1,1,1, parity 0, stop 1 (11 cycles).
  - Receiver at prescaler 8 reports P_DATA = 8'b11100100, no Parity_Error.
- Odd parity: PAR_EN = 1, PAR_TYP = 1, P_DATA = 8'b10111010 (five 1s).
  - Required: parity bit = 0.
  - With P_DATA = 8'hFF: parity bit = 1.
- Back-to-back: Data_Valid asserted during the STOP cycle with P_DATA = 8'h3C.
  - Required: start bit on the very next cycle, busy never drops, second frame correct.
- Ignored request and config change: Data_Valid pulse mid-DATA with P_DATA = 8'h55.
  - Required: pulse dropped, the in-flight frame is unchanged, state returns to IDLE afterwards.
  - Toggling PAR_TYP mid-frame does not change the parity bit.
- Reset mid-frame: assert reset during data bit 4.
  - Required: TX_OUT = 1 and busy = 0 within the same timestep (asynchronous).
  - After release, a new Data_Valid produces a complete, correct frame.
